// File: rtl/lab06_result_buf.sv
// Show-ahead result FIFO behind lab06_2, with drop accounting and a saturating
// running sum of every accepted result.
module lab06_result_buf #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [6:0]        in_result,
    input  logic                     rd_ready,
    input  logic                     sum_clr,
    output logic                     rd_valid,
    output logic signed [6:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop,
    output logic [3:0]               drop_cnt,
    output logic signed [9:0]        sum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic signed [6:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_drop;
    logic [3:0]         r_drop_cnt;
    logic signed [9:0]  r_sum;

    logic               w_rd;
    logic               w_wr;
    logic               w_rej;
    logic signed [10:0] w_sum_ext;
    logic signed [9:0]  w_sum_sat;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign rd_valid = !empty;
    assign count    = r_count;
    assign drop     = r_drop;
    assign drop_cnt = r_drop_cnt;
    assign sum      = r_sum;
    assign rd_data  = empty ? 7'sd0 : r_mem[r_rd_ptr];

    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_rd  = rd_valid && rd_ready;
    assign w_wr  = in_valid && (!full || w_rd);
    assign w_rej = in_valid && full && !w_rd;

    // One extra bit catches overflow: top two bits differ only when the true sum left 10-bit range.
    assign w_sum_ext = {r_sum[9], r_sum} + {{4{in_result[6]}}, in_result};
    always_comb begin
        w_sum_sat = w_sum_ext[9:0];
        if (w_sum_ext[10] != w_sum_ext[9])
            w_sum_sat = w_sum_ext[10] ? -10'sd512 : 10'sd511;
    end

    // NOTE: storage is not reset; clearing count makes old entries unreachable,
    // and rd_data is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= in_result;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop <= w_rej;
            if (w_rej && r_drop_cnt != 4'hF)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (sum_clr) begin
            r_sum <= w_wr ? 10'(in_result) : 10'sd0;
        end else if (w_wr) begin
            r_sum <= w_sum_sat;
        end
    end

endmodule

// File: tb/tb_lab06_result_buf.sv
// Directed bench for lab06_result_buf: ordering, full/drop, wrap, sum saturation,
// clear priority and asynchronous reset, against hand-computed values.
module tb_lab06_result_buf;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic signed [6:0] in_result;
    logic              rd_ready;
    logic              sum_clr;
    logic              rd_valid;
    logic signed [6:0] rd_data;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic              drop;
    logic [3:0]        drop_cnt;
    logic signed [9:0] sum;

    int n_checks = 0;
    int n_pass   = 0;

    lab06_result_buf #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_result (in_result),
        .rd_ready  (rd_ready),
        .sum_clr   (sum_clr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop      (drop),
        .drop_cnt  (drop_cnt),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v);
        in_valid  = 1'b1;
        in_result = 7'(v);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; rd_ready = 1'b0; sum_clr = 1'b0;
        #1;
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(count), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_full", int'(full), 0);
        #12 rst_n = 1'b1;
        step();

        // Ordering; also no same-cycle bypass while empty.
        in_valid = 1'b1; in_result = 7'sd3;
        #1 check("no_bypass", int'(rd_valid), 0);
        step();
        check("first_vis", int'(rd_data), 3);
        wr(-5);
        wr(63);
        in_valid = 1'b0;
        check("ord_count", int'(count), 3);
        check("ord_sum", int'(sum), 61);
        check("ord_head", int'(rd_data), 3);
        rd_ready = 1'b1;
        step(); check("ord_rd1", int'(rd_data), -5);
        step(); check("ord_rd2", int'(rd_data), 63);
        step(); check("ord_empty", int'(empty), 1);
        check("ord_empty_data", int'(rd_data), 0);
        rd_ready = 1'b0;

        // Full boundary; pointers wrap (entries land at slots 3,0,1,2 then 3).
        wr(1); wr(2); wr(3); wr(4);
        check("full_flag", int'(full), 1);
        check("full_sum", int'(sum), 71);
        wr(9);
        check("drop_pulse", int'(drop), 1);
        check("drop_cnt1", int'(drop_cnt), 1);
        check("drop_count", int'(count), 4);
        check("drop_no_sum", int'(sum), 71);
        in_valid = 1'b0;
        step();
        check("drop_one_cycle", int'(drop), 0);
        rd_ready = 1'b1;
        wr(9);
        in_valid = 1'b0;
        check("rw_count", int'(count), 4);
        check("rw_sum", int'(sum), 80);
        check("rw_head", int'(rd_data), 2);
        step(); check("wrap_rd3", int'(rd_data), 3);
        step(); check("wrap_rd4", int'(rd_data), 4);
        step(); check("wrap_rd9", int'(rd_data), 9);
        step(); check("wrap_empty", int'(empty), 1);

        // Sum saturation; rd_ready stays high so the FIFO never fills.
        sum_clr = 1'b1; step(); sum_clr = 1'b0;
        check("clr_sum", int'(sum), 0);
        check("clr_keeps_drop_cnt", int'(drop_cnt), 1);
        for (int i = 0; i < 9; i++) wr(63);
        in_valid = 1'b0;
        check("sat_pos", int'(sum), 511);
        sum_clr = 1'b1; step(); sum_clr = 1'b0;
        for (int i = 0; i < 9; i++) wr(-64);
        in_valid = 1'b0;
        check("sat_neg", int'(sum), -512);
        step();
        check("sat_drain", int'(empty), 1);
        rd_ready = 1'b0;

        // Clear together with an accepted write.
        sum_clr = 1'b1;
        wr(20);
        check("clrw_sum20", int'(sum), 20);
        wr(-7);
        sum_clr = 1'b0; in_valid = 1'b0;
        check("clrw_sum", int'(sum), -7);
        check("clrw_count", int'(count), 2);

        // Asynchronous reset between edges.
        rst_n = 1'b0;
        #1;
        check("arst_count", int'(count), 0);
        check("arst_rd_valid", int'(rd_valid), 0);
        check("arst_sum", int'(sum), 0);
        check("arst_rd_data", int'(rd_data), 0);
        #1 rst_n = 1'b1;
        wr(5);
        in_valid = 1'b0;
        check("post_rst_count", int'(count), 1);
        check("post_rst_data", int'(rd_data), 5);

        // drop_cnt saturation at 15.
        wr(1); wr(1); wr(1);
        check("sat_fill", int'(full), 1);
        for (int i = 0; i < 17; i++) wr(-1);
        check("dcnt_sat", int'(drop_cnt), 15);
        check("dcnt_drop", int'(drop), 1);
        in_valid = 1'b0;
        step();
        check("dcnt_drop_end", int'(drop), 0);
        check("dcnt_sum", int'(sum), 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
